// File: rtl/pong_pkg.sv
// Shared game-state encodings, default geometry and small arithmetic helpers.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } game_state_t;

  localparam int DEF_SCREEN_W     = 640;
  localparam int DEF_SCREEN_H     = 480;
  localparam int DEF_PADDLE_W     = 8;
  localparam int DEF_PADDLE_H     = 64;
  localparam int DEF_BALL_SIZE    = 8;
  localparam int DEF_L_PADDLE_X   = 16;
  localparam int DEF_R_PADDLE_X   = 616;
  localparam int DEF_PADDLE_SPEED = 4;
  localparam int DEF_BALL_SPEED   = 2;
  localparam int DEF_SERVE_FRAMES = 60;
  localparam int DEF_WIN_SCORE    = 9;

  // One frame of paddle motion: up/down clamped to [0, lim]; both or neither hold.
  function automatic logic [9:0] paddle_step(input logic [9:0] pad, input logic up,
                                             input logic dn, input logic [9:0] spd,
                                             input logic [9:0] lim);
    logic [9:0] r;
    r = pad;
    if (up && !dn)
      r = (pad < spd) ? '0 : pad - spd;
    else if (dn && !up)
      r = (({1'b0, pad} + {1'b0, spd}) >= {1'b0, lim}) ? lim : pad + spd;
    return r;
  endfunction

  // Score increment that sticks at the winning score.
  function automatic logic [3:0] sat_inc(input logic [3:0] s, input logic [3:0] lim);
    return (s >= lim) ? s : s + 4'd1;
  endfunction

endpackage

// File: rtl/pong_input_sync.sv
// Button synchronizers and vsync falling-edge frame tick.
module pong_input_sync
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic [4:0] btn_raw,
  output logic [4:0] btn,
  output logic       tick
);

  logic [4:0] sync1;
  logic       vsync_q;

  // Two-flop synchronizers for buttons; single register on vsync (idle high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= '0;
      btn     <= '0;
      vsync_q <= 1'b1;
    end else begin
      sync1   <= btn_raw;
      btn     <= sync1;
      vsync_q <= vsync;
    end
  end

  assign tick = vsync_q & ~vsync;

endmodule

// File: rtl/pong_ctrl.sv
// Pong game controller: FSM, serve counter, paddle and ball datapath, scores.
module pong_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_W     = DEF_SCREEN_W,
  parameter int SCREEN_H     = DEF_SCREEN_H,
  parameter int PADDLE_W     = DEF_PADDLE_W,
  parameter int PADDLE_H     = DEF_PADDLE_H,
  parameter int BALL_SIZE    = DEF_BALL_SIZE,
  parameter int L_PADDLE_X   = DEF_L_PADDLE_X,
  parameter int R_PADDLE_X   = DEF_R_PADDLE_X,
  parameter int PADDLE_SPEED = DEF_PADDLE_SPEED,
  parameter int BALL_SPEED   = DEF_BALL_SPEED,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int WIN_SCORE    = DEF_WIN_SCORE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       btn_l_up,
  input  logic       btn_l_dn,
  input  logic       btn_r_up,
  input  logic       btn_r_dn,
  input  logic       btn_start,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] pad_l_y,
  output logic [9:0] pad_r_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] game_state
);

  localparam logic signed [10:0] SPD_B  = 11'(BALL_SPEED);
  localparam logic signed [10:0] X_MAX  = 11'(SCREEN_W - BALL_SIZE);
  localparam logic signed [10:0] Y_MAX  = 11'(SCREEN_H - BALL_SIZE);
  localparam logic signed [10:0] L_EDGE = 11'(L_PADDLE_X + PADDLE_W);
  localparam logic signed [10:0] R_EDGE = 11'(R_PADDLE_X - BALL_SIZE);
  localparam logic [10:0] BS_U     = 11'(BALL_SIZE);
  localparam logic [10:0] PH_U     = 11'(PADDLE_H);
  localparam logic [9:0]  BALL_CX  = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0]  BALL_CY  = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [9:0]  PAD_MAX  = 10'(SCREEN_H - PADDLE_H);
  localparam logic [9:0]  PAD_C    = 10'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [9:0]  PAD_SPD  = 10'(PADDLE_SPEED);
  localparam logic [7:0]  SERVE_LD = 8'(SERVE_FRAMES - 1);
  localparam logic [3:0]  WIN      = 4'(WIN_SCORE);

  logic [4:0] btn;
  logic       tick;

  pong_input_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .vsync   (vsync),
    .btn_raw ({btn_start, btn_r_dn, btn_r_up, btn_l_dn, btn_l_up}),
    .btn     (btn),
    .tick    (tick)
  );

  game_state_t state, state_nxt;
  logic        dx_right, dy_down, dx_nxt, dy_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [9:0]  bx_nxt, by_nxt, pl_nxt, pr_nxt;
  logic [3:0]  sl_nxt, sr_nxt, sl_inc, sr_inc;
  logic signed [10:0] bx, by, nx, ny;
  logic [10:0] ball_bot;
  logic        ov_l, ov_r, hit_l, hit_r;

  // State and datapath registers; everything loads only from the next-state logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ball_x   <= BALL_CX;
      ball_y   <= BALL_CY;
      pad_l_y  <= PAD_C;
      pad_r_y  <= PAD_C;
      score_l  <= '0;
      score_r  <= '0;
      dx_right <= 1'b1;
      dy_down  <= 1'b1;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      ball_x   <= bx_nxt;
      ball_y   <= by_nxt;
      pad_l_y  <= pl_nxt;
      pad_r_y  <= pr_nxt;
      score_l  <= sl_nxt;
      score_r  <= sr_nxt;
      dx_right <= dx_nxt;
      dy_down  <= dy_nxt;
      cnt      <= cnt_nxt;
    end
  end

  // Next-state, motion, collision and scoring, all gated by the frame tick.
  always_comb begin
    state_nxt = state;
    bx_nxt    = ball_x;
    by_nxt    = ball_y;
    pl_nxt    = pad_l_y;
    pr_nxt    = pad_r_y;
    sl_nxt    = score_l;
    sr_nxt    = score_r;
    dx_nxt    = dx_right;
    dy_nxt    = dy_down;
    cnt_nxt   = cnt;

    bx       = $signed({1'b0, ball_x});
    by       = $signed({1'b0, ball_y});
    nx       = dx_right ? bx + SPD_B : bx - SPD_B;
    ny       = dy_down  ? by + SPD_B : by - SPD_B;
    ball_bot = {1'b0, ball_y} + BS_U;
    ov_l     = (ball_bot > {1'b0, pad_l_y}) && ({1'b0, ball_y} < ({1'b0, pad_l_y} + PH_U));
    ov_r     = (ball_bot > {1'b0, pad_r_y}) && ({1'b0, ball_y} < ({1'b0, pad_r_y} + PH_U));
    hit_l    = !dx_right && (bx >= L_EDGE) && (nx <= L_EDGE) && ov_l;
    hit_r    =  dx_right && (bx <= R_EDGE) && (nx >= R_EDGE) && ov_r;
    sl_inc   = sat_inc(score_l, WIN);
    sr_inc   = sat_inc(score_r, WIN);

    if (tick) begin
      unique case (state)
        ST_IDLE: begin
          bx_nxt = BALL_CX;
          by_nxt = BALL_CY;
          pl_nxt = PAD_C;
          pr_nxt = PAD_C;
          if (btn[4]) begin
            sl_nxt    = '0;
            sr_nxt    = '0;
            cnt_nxt   = SERVE_LD;
            state_nxt = ST_SERVE;
          end
        end
        ST_SERVE: begin
          pl_nxt = paddle_step(pad_l_y, btn[0], btn[1], PAD_SPD, PAD_MAX);
          pr_nxt = paddle_step(pad_r_y, btn[2], btn[3], PAD_SPD, PAD_MAX);
          if (cnt == '0) state_nxt = ST_PLAY;
          else           cnt_nxt   = cnt - 8'd1;
        end
        ST_PLAY: begin
          pl_nxt = paddle_step(pad_l_y, btn[0], btn[1], PAD_SPD, PAD_MAX);
          pr_nxt = paddle_step(pad_r_y, btn[2], btn[3], PAD_SPD, PAD_MAX);
          if (ny <= 11'sd0) begin
            by_nxt = '0;
            dy_nxt = 1'b1;
          end else if (ny >= Y_MAX) begin
            by_nxt = Y_MAX[9:0];
            dy_nxt = 1'b0;
          end else begin
            by_nxt = ny[9:0];
          end
          // A miss overrides the wall result: the ball is recentred and dy kept as it was.
          if (hit_l) begin
            bx_nxt = L_EDGE[9:0];
            dx_nxt = 1'b1;
          end else if (hit_r) begin
            bx_nxt = R_EDGE[9:0];
            dx_nxt = 1'b0;
          end else if (nx <= 11'sd0 || nx >= X_MAX) begin
            bx_nxt  = BALL_CX;
            by_nxt  = BALL_CY;
            dy_nxt  = dy_down;
            cnt_nxt = SERVE_LD;
            if (nx <= 11'sd0) begin
              sr_nxt    = sr_inc;
              dx_nxt    = 1'b0;
              state_nxt = (sr_inc == WIN) ? ST_OVER : ST_SERVE;
            end else begin
              sl_nxt    = sl_inc;
              dx_nxt    = 1'b1;
              state_nxt = (sl_inc == WIN) ? ST_OVER : ST_SERVE;
            end
          end else begin
            bx_nxt = nx[9:0];
          end
        end
        ST_OVER: begin
          if (btn[4]) begin
            bx_nxt    = BALL_CX;
            by_nxt    = BALL_CY;
            pl_nxt    = PAD_C;
            pr_nxt    = PAD_C;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign game_state = state;

endmodule
